// File: rtl/seg7_multidigit_ctrl_pkg.sv
// Shared types, segment lookup and FSM encoding for the seven-segment controller.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } fsm_state_t;

  function automatic seg_t bcd_to_seg(input logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_LUT[digit] : SEG_BLANK;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_multidigit_ctrl_if.sv
// Value-source handshake into the seven-segment controller.
interface seg7_multidigit_ctrl_if #(
  parameter int unsigned IN_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_value;

  modport master (output in_valid, output in_value, input  in_ready);
  modport slave  (input  in_valid, input  in_value, output in_ready);
endinterface

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, result mod 10**NUM_DIGITS.
module seg7_bin2bcd #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [IN_WIDTH-1:0]     i_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  logic [IN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic [BCD_W-1:0]    w_adj;
  logic                w_last;

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  assign w_last = r_busy && (r_cnt == CNT_W'(IN_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_value;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // Top BCD bit is dropped, so only the low NUM_DIGITS decimal digits survive
      {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + CNT_W'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg7_multidigit_ctrl.sv
// Multi-digit 7-seg controller: BCD conversion, registered patterns, anode scan.
// Optional SEG7_LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_multidigit_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg7_multidigit_ctrl_if.slave   bus,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_all,
  output logic [6:0]              seg_mux,
  output logic [NUM_DIGITS-1:0]   an_n
);
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] LIMIT  = pow10(NUM_DIGITS);
  localparam bit OVF_POSSIBLE    = (IN_WIDTH >= 64) || (LIMIT <= ((64'd1 << IN_WIDTH) - 64'd1));
  localparam logic [IN_WIDTH-1:0] LIMIT_W = IN_WIDTH'(LIMIT);

  fsm_state_t r_state, w_state_next;

  logic                    w_ready, w_accept, w_ovf_in;
  logic                    w_busy, w_conv_done;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  seg_t [NUM_DIGITS-1:0]   w_seg_dec;
  seg_t [NUM_DIGITS-1:0]   r_seg;
  logic                    r_ovf_pend, r_ovf, r_done;
  logic [SCAN_W-1:0]       r_scan_cnt;
  logic [IDX_W-1:0]        r_idx;
  seg_t                    r_seg_mux;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    w_wrap;

  seg7_bin2bcd #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_accept),
    .i_value(bus.in_value),
    .o_busy (w_busy),
    .o_done (w_conv_done),
    .o_bcd  (w_bcd)
  );

  assign w_ready  = (r_state != SHIFT) && !w_busy;
  assign w_accept = bus.in_valid && w_ready;
  assign w_ovf_in = OVF_POSSIBLE && (bus.in_value >= LIMIT_W);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = SHIFT;
      SHIFT:   if (w_conv_done) w_state_next = LATCH;
      LATCH:   w_state_next = w_accept ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  logic       w_seen;
  logic [3:0] w_digit;
  // Walk from the most significant digit; once a non-zero digit is seen all lower ones show
  always_comb begin
    w_seen    = 1'b0;
    w_digit   = '0;
    w_seg_dec = '1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      w_digit = w_bcd[4*(NUM_DIGITS-1-j) +: 4];
      if (w_digit != 4'd0 || j == NUM_DIGITS - 1) w_seen = 1'b1;
      w_seg_dec[NUM_DIGITS-1-j] = w_seen ? bcd_to_seg(w_digit) : SEG_BLANK;
    end
  end
`else
  always_comb begin
    w_seg_dec = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      w_seg_dec[d] = bcd_to_seg(w_bcd[4*d +: 4]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= '1;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == LATCH);
      if (r_state == LATCH) begin
        r_seg <= w_seg_dec;
        r_ovf <= r_ovf_pend;
      end
      if (w_accept) r_ovf_pend <= w_ovf_in;
    end
  end

  assign w_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_seg_mux  <= SEG_BLANK;
      r_an_n     <= '1;
    end else if (w_wrap) begin
      r_scan_cnt <= '0;
      r_an_n     <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg_mux  <= r_seg[r_idx];
      r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign bus.in_ready = w_ready;
  assign done         = r_done;
  assign overflow     = r_ovf;
  assign seg_all      = r_seg;
  assign seg_mux      = r_seg_mux;
  assign an_n         = r_an_n;

endmodule
